// File: rtl/bcd_accum_2dig.sv
// Two-digit BCD accumulator. Each accepted tens/ones pair is added into a
// three-digit BCD running sum, one digit per cycle, with a ripple carry.
module bcd_accum_2dig (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clear_i,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    input  logic [3:0] dig1_i,
    input  logic [3:0] dig2_i,
    output logic [3:0] sum_hund_o,
    output logic [3:0] sum_tens_o,
    output logic [3:0] sum_ones_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       overflow_o,
    output logic       err_o
);

    // state    | meaning
    // S_IDLE   | waiting for a handshake
    // S_ONES   | adding latched ones digit
    // S_TENS   | adding latched tens digit plus carry
    // S_HUND   | propagating carry into hundreds
    // S_DONE   | sum final for one cycle; may accept the next value
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ONES = 3'd1;
    localparam logic [2:0] S_TENS = 3'd2;
    localparam logic [2:0] S_HUND = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0] state_q, state_d;
    logic [3:0] dig1_q, dig1_d;
    logic [3:0] dig2_q, dig2_d;
    logic [3:0] sum_hund_q, sum_hund_d;
    logic [3:0] sum_tens_q, sum_tens_d;
    logic [3:0] sum_ones_q, sum_ones_d;
    logic       carry_q, carry_d;
    logic       ovf_q, ovf_d;
    logic       err_q, err_d;

    logic       handshake;
    logic       dig_bad;
    logic [4:0] t_ones, t_tens, t_hund;
    logic [4:0] ones_adj, tens_adj;

    assign in_ready_o = ((state_q == S_IDLE) || (state_q == S_DONE)) && !clear_i;
    assign handshake  = in_valid_i && in_ready_o;
    assign dig_bad    = (dig1_i > 4'd9) || (dig2_i > 4'd9);

    assign t_ones   = {1'b0, sum_ones_q} + {1'b0, dig2_q};
    assign t_tens   = {1'b0, sum_tens_q} + {1'b0, dig1_q} + {4'b0, carry_q};
    assign t_hund   = {1'b0, sum_hund_q} + {4'b0, carry_q};
    assign ones_adj = t_ones - 5'd10;
    assign tens_adj = t_tens - 5'd10;

    always_comb begin
        state_d    = state_q;
        dig1_d     = dig1_q;
        dig2_d     = dig2_q;
        sum_hund_d = sum_hund_q;
        sum_tens_d = sum_tens_q;
        sum_ones_d = sum_ones_q;
        carry_d    = carry_q;
        ovf_d      = ovf_q;
        err_d      = err_q;
        if (clear_i) begin
            state_d    = S_IDLE;
            sum_hund_d = 4'd0;
            sum_tens_d = 4'd0;
            sum_ones_d = 4'd0;
            carry_d    = 1'b0;
            ovf_d      = 1'b0;
            err_d      = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    state_d = S_IDLE;
                    if (handshake) begin
                        if (dig_bad) begin
                            err_d = 1'b1;
                        end else begin
                            dig1_d  = dig1_i;
                            dig2_d  = dig2_i;
                            state_d = S_ONES;
                        end
                    end
                end
                S_ONES: begin
                    if (t_ones > 5'd9) begin
                        sum_ones_d = ones_adj[3:0];
                        carry_d    = 1'b1;
                    end else begin
                        sum_ones_d = t_ones[3:0];
                        carry_d    = 1'b0;
                    end
                    state_d = S_TENS;
                end
                S_TENS: begin
                    if (t_tens > 5'd9) begin
                        sum_tens_d = tens_adj[3:0];
                        carry_d    = 1'b1;
                    end else begin
                        sum_tens_d = t_tens[3:0];
                        carry_d    = 1'b0;
                    end
                    state_d = S_HUND;
                end
                S_HUND: begin
                    // Hundreds can only ever reach 10, so wrap straight to 0.
                    if (t_hund > 5'd9) begin
                        sum_hund_d = 4'd0;
                        ovf_d      = 1'b1;
                    end else begin
                        sum_hund_d = t_hund[3:0];
                    end
                    carry_d = 1'b0;
                    state_d = S_DONE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            dig1_q     <= 4'd0;
            dig2_q     <= 4'd0;
            sum_hund_q <= 4'd0;
            sum_tens_q <= 4'd0;
            sum_ones_q <= 4'd0;
            carry_q    <= 1'b0;
            ovf_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            dig1_q     <= dig1_d;
            dig2_q     <= dig2_d;
            sum_hund_q <= sum_hund_d;
            sum_tens_q <= sum_tens_d;
            sum_ones_q <= sum_ones_d;
            carry_q    <= carry_d;
            ovf_q      <= ovf_d;
            err_q      <= err_d;
        end
    end

    assign sum_hund_o = sum_hund_q;
    assign sum_tens_o = sum_tens_q;
    assign sum_ones_o = sum_ones_q;
    assign busy_o     = (state_q == S_ONES) || (state_q == S_TENS) || (state_q == S_HUND);
    assign done_o     = (state_q == S_DONE);
    assign overflow_o = ovf_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_bcd_accum_2dig.sv
// Scoreboard bench for bcd_accum_2dig: a decimal model pushes the expected
// sum on every accepted value and a monitor compares it on each done pulse.
module tb_bcd_accum_2dig;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       clear_i = 1'b0;
    logic       in_valid_i = 1'b0;
    logic       in_ready_o;
    logic [3:0] dig1_i = 4'd0;
    logic [3:0] dig2_i = 4'd0;
    logic [3:0] sum_hund_o, sum_tens_o, sum_ones_o;
    logic       busy_o, done_o, overflow_o, err_o;

    bcd_accum_2dig dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clear_i    (clear_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .dig1_i     (dig1_i),
        .dig2_i     (dig2_i),
        .sum_hund_o (sum_hund_o),
        .sum_tens_o (sum_tens_o),
        .sum_ones_o (sum_ones_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .overflow_o (overflow_o),
        .err_o      (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int   sum;
        logic ovf;
    } exp_t;

    exp_t sb_q[$];
    int   model_sum = 0;
    logic model_ovf = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic logic [31:0] to_bcd(input int v);
        logic [3:0] h, t, o;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        o = 4'(v % 10);
        return {20'd0, h, t, o};
    endfunction

    function automatic logic [31:0] dut_sum();
        return {20'd0, sum_hund_o, sum_tens_o, sum_ones_o};
    endfunction

    task automatic model_accept(input logic [3:0] d1, input logic [3:0] d2);
        exp_t e;
        model_sum = model_sum + int'(d1) * 10 + int'(d2);
        if (model_sum > 999) begin
            model_sum = model_sum - 1000;
            model_ovf = 1'b1;
        end
        e.sum = model_sum;
        e.ovf = model_ovf;
        sb_q.push_back(e);
    endtask

    task automatic model_reset();
        sb_q.delete();
        model_sum = 0;
        model_ovf = 1'b0;
    endtask

    always @(negedge clk_i) begin
        if (done_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexp_done", {31'd0, done_o}, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("sum", dut_sum(), to_bcd(e.sum));
                check("ovf", {31'd0, overflow_o}, {31'd0, e.ovf});
            end
        end
    end

    // Called just after a rising edge; returns just after the handshake edge.
    task automatic send(input logic [3:0] d1, input logic [3:0] d2);
        int n;
        in_valid_i = 1'b1;
        dig1_i = d1;
        dig2_i = d2;
        n = 0;
        @(negedge clk_i);
        while (in_ready_o !== 1'b1 && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        if (in_ready_o !== 1'b1) check("hs_timeout", {31'd0, in_ready_o}, 32'd1);
        else if (d1 <= 4'd9 && d2 <= 4'd9) model_accept(d1, d2);
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_i = 1'b1;
        @(posedge clk_i);
        #1;
        clear_i = 1'b0;
        model_reset();
    endtask

    task automatic idle_wait();
        repeat (6) @(posedge clk_i);
        #1;
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_sum", dut_sum(), 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_done", {31'd0, done_o}, 32'd0);
        check("rst_flags", {30'd0, overflow_o, err_o}, 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check("ready_after_rst", {31'd0, in_ready_o}, 32'd1);
        @(posedge clk_i);
        #1;

        // 47 then 58, with latency check on the first
        send(4'd4, 4'd7);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk_i);
            check("lat_busy", {31'd0, busy_o}, 32'd1);
            check("lat_ready", {31'd0, in_ready_o}, 32'd0);
            check("lat_nodone", {31'd0, done_o}, 32'd0);
        end
        @(negedge clk_i);
        check("lat_done", {31'd0, done_o}, 32'd1);
        check("lat_ready_done", {31'd0, in_ready_o}, 32'd1);
        @(posedge clk_i);
        #1;
        send(4'd5, 4'd8);
        idle_wait();

        // eleven back-to-back 99s with in_valid held
        pulse_clear();
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b1;
        dig1_i = 4'd9;
        dig2_i = 4'd9;
        for (int c = 0; c < 44; c++) begin
            @(negedge clk_i);
            check("b2b_ready", {31'd0, in_ready_o}, (c % 4 == 0) ? 32'd1 : 32'd0);
            if (c % 4 == 0) model_accept(4'd9, 4'd9);
            @(posedge clk_i);
            #1;
            if (c == 40) in_valid_i = 1'b0;
        end
        idle_wait();
        check("b2b_final", dut_sum(), to_bcd(89));
        check("b2b_ovf", {31'd0, overflow_o}, 32'd1);

        // illegal digit rejected
        pulse_clear();
        send(4'hA, 4'd3);
        @(negedge clk_i);
        check("bad_err", {31'd0, err_o}, 32'd1);
        check("bad_ready", {31'd0, in_ready_o}, 32'd1);
        check("bad_busy", {31'd0, busy_o}, 32'd0);
        check("bad_sum", dut_sum(), 32'd0);
        repeat (4) begin
            @(negedge clk_i);
            check("bad_nodone", {31'd0, done_o}, 32'd0);
        end
        @(posedge clk_i);
        #1;
        send(4'd1, 4'd2);
        idle_wait();
        check("bad_err_sticky", {31'd0, err_o}, 32'd1);

        // clear in the ADD_TENS cycle
        pulse_clear();
        send(4'd0, 4'd1);
        idle_wait();
        send(4'd9, 4'd9);
        @(posedge clk_i);
        #1;
        clear_i = 1'b1;
        @(posedge clk_i);
        #1;
        clear_i = 1'b0;
        model_reset();
        @(negedge clk_i);
        check("clr_sum", dut_sum(), 32'd0);
        check("clr_flags", {30'd0, overflow_o, err_o}, 32'd0);
        check("clr_busy", {31'd0, busy_o}, 32'd0);
        check("clr_ready", {31'd0, in_ready_o}, 32'd1);
        repeat (5) begin
            @(negedge clk_i);
            check("clr_nodone", {31'd0, done_o}, 32'd0);
        end
        @(posedge clk_i);
        #1;

        // reset in ADD_HUND beats clear and in_valid
        send(4'd3, 4'd3);
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        clear_i = 1'b1;
        in_valid_i = 1'b1;
        dig1_i = 4'd5;
        dig2_i = 4'd5;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        clear_i = 1'b0;
        in_valid_i = 1'b0;
        model_reset();
        @(negedge clk_i);
        check("rst2_sum", dut_sum(), 32'd0);
        check("rst2_stat", {28'd0, busy_o, done_o, overflow_o, err_o}, 32'd0);
        check("rst2_ready", {31'd0, in_ready_o}, 32'd1);
        @(negedge clk_i);
        check("rst2_noaccept", {31'd0, busy_o}, 32'd0);
        @(posedge clk_i);
        #1;
        send(4'd0, 4'd5);
        idle_wait();
        check("rst2_next", dut_sum(), to_bcd(5));

        // inputs change after handshake
        pulse_clear();
        send(4'd2, 4'd1);
        dig1_i = 4'd9;
        dig2_i = 4'd9;
        idle_wait();
        check("latch_sum", dut_sum(), to_bcd(21));

        check("sb_empty", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
